// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the MIPS CPU bus master: access size, FSM states, lane masks.
// Ports: none (package).
// decode_size() folds the 2-bit CPU size code onto size_t (code 3 behaves as a word).
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Lane masks for an access at byte offset 0; shifted left by the offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic size_t decode_size(input logic [1:0] code);
    case (code)
      2'd0:    return BYTE;
      2'd1:    return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lane.sv
// Byte-lane helper for the bus master: byteenable, store steering, load extraction.
// Ports: size/sign_ext/offset describe the access; wdata/rdata in; byteenable/wlane/rext out.
// Purely combinational; the caller must pass an offset already aligned to the size.
module mips_cpu_bus_lane
  import mips_cpu_bus_pkg::*;
(
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt  = {offset, 3'b000};
  assign rshift = rdata >> shamt;

  always_comb begin
    byteenable = '0;
    wlane      = '0;
    rext       = '0;
    case (size)
      BYTE: begin
        byteenable = BE_BYTE << offset;
        wlane      = {24'b0, wdata[7:0]} << shamt;
        rext       = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
      end
      HALF: begin
        byteenable = BE_HALF << offset;
        wlane      = {16'b0, wdata[15:0]} << shamt;
        rext       = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
      end
      default: begin
        byteenable = BE_WORD;
        wlane      = wdata;
        rext       = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Avalon-MM style initiator: one CPU byte/half/word load or store at a time onto a
// word-addressed bus, with waitrequest stalls and fixed one-cycle read latency.
// Ports: clk/reset_n; CPU side req_* / resp_*; bus side address, read, write,
// waitrequest, writedata, byteenable, readdata.
// Optional: define MIPS_CPU_MISALIGN_TRAP_EN to reject misaligned half/word accesses
// with resp_err instead of silently aligning them.
module mips_cpu_bus_master
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  state_t      state;
  size_t       req_sz;
  logic [1:0]  req_off;

  // Fields held for the load-extraction side while the bus cycle runs.
  size_t       lat_size;
  logic        lat_signed;
  logic        lat_write;
  logic [1:0]  lat_off;

  logic [3:0]  req_be;
  logic [31:0] req_wlane;
  logic [31:0] rd_rext;

  logic [31:0] unused_req_rext;
  logic [3:0]  unused_rd_be;
  logic [31:0] unused_rd_wlane;

  assign req_sz = decode_size(req_size);

  // Offending low bits are dropped so a misaligned access proceeds aligned.
  always_comb begin
    req_off = req_addr[1:0];
    case (req_sz)
      HALF:    req_off = {req_addr[1], 1'b0};
      WORD:    req_off = 2'b00;
      default: req_off = req_addr[1:0];
    endcase
  end

  mips_cpu_bus_lane u_lane_req (
    .size       (req_sz),
    .sign_ext   (1'b0),
    .offset     (req_off),
    .wdata      (req_wdata),
    .rdata      (32'd0),
    .byteenable (req_be),
    .wlane      (req_wlane),
    .rext       (unused_req_rext)
  );

  mips_cpu_bus_lane u_lane_rd (
    .size       (lat_size),
    .sign_ext   (lat_signed),
    .offset     (lat_off),
    .wdata      (writedata),
    .rdata      (readdata),
    .byteenable (unused_rd_be),
    .wlane      (unused_rd_wlane),
    .rext       (rd_rext)
  );

`ifdef MIPS_CPU_MISALIGN_TRAP_EN
  logic misaligned;
  logic resp_err_q;

  assign misaligned = ((req_sz == HALF) && req_addr[0]) ||
                      ((req_sz == WORD) && (req_addr[1:0] != 2'b00));
  assign resp_err   = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      lat_size   <= BYTE;
      lat_signed <= 1'b0;
      lat_write  <= 1'b0;
      lat_off    <= 2'b00;
`ifdef MIPS_CPU_MISALIGN_TRAP_EN
      resp_err_q <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            lat_size   <= req_sz;
            lat_signed <= req_signed;
            lat_write  <= req_write;
            lat_off    <= req_off;
`ifdef MIPS_CPU_MISALIGN_TRAP_EN
            if (misaligned) begin
              // No bus cycle: answer straight away with an error and zero data.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err_q <= 1'b1;
              resp_rdata <= '0;
            end else
`endif
            begin
              state      <= REQ;
              read       <= !req_write;
              write      <= req_write;
              address    <= 32'(req_addr & ~ADDR_W'(3));
              byteenable <= req_be;
              writedata  <= req_wlane;
            end
          end
        end
        REQ: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (lat_write) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          // readdata is valid exactly one cycle after the read was accepted.
          // resp_rdata only changes when a load completes, so stores leave it as is.
          resp_rdata <= rd_rext;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
`ifdef MIPS_CPU_MISALIGN_TRAP_EN
          resp_err_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed bench for mips_cpu_bus_master: stores, loads, wait states, misalignment,
// reset abort and back-to-back requests. Inputs change and outputs are sampled on
// the falling edge; the slave model returns readdata one cycle after an accepted read.
module tb_mips_cpu_bus_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  logic [31:0] mem_word;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          resp_count = 0;
  int          strobe_clash = 0;

  mips_cpu_bus_master #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: data for an accepted read appears on the following cycle; junk otherwise.
  always @(posedge clk) begin
    readdata <= (read && !waitrequest) ? mem_word : 32'h0BAD_0BAD;
  end

  always @(negedge clk) begin
    if (resp_valid) resp_count++;
    if (read && write) strobe_clash++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // Issue a zero-wait load from the current falling edge and check the result in RESP.
  task automatic load_zero_wait(input string tag, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] mem,
                                input logic [3:0] exp_be, input logic [31:0] exp_data);
    mem_word = mem;
    drive_req(1'b0, sz, sg, a, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_read"}, {31'b0, read}, 32'd1);
    check({tag, "_be"}, {28'b0, byteenable}, {28'b0, exp_be});
    @(negedge clk);
    check({tag, "_rdwait_rv"}, {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_data"}, resp_rdata, exp_data);
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    waitrequest = 1'b0;
    mem_word    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_read", {31'b0, read}, 32'd0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_be", {28'b0, byteenable}, 32'd0);
    check("rst_rv", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // Word store, zero wait
    drive_req(1'b1, 2'd2, 1'b0, 32'hBFC0_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    check("sw_write", {31'b0, write}, 32'd1);
    check("sw_read", {31'b0, read}, 32'd0);
    check("sw_addr", address, 32'hBFC0_0010);
    check("sw_be", {28'b0, byteenable}, 32'hF);
    check("sw_wdata", writedata, 32'hDEAD_BEEF);
    check("sw_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("sw_rv", {31'b0, resp_valid}, 32'd1);
    check("sw_write_off", {31'b0, write}, 32'd0);
    @(negedge clk);
    check("sw_rv_pulse", {31'b0, resp_valid}, 32'd0);
    check("sw_ready_back", {31'b0, req_ready}, 32'd1);

    // Byte loads from the top lane, signed and unsigned
    load_zero_wait("lb", 2'd0, 1'b1, 32'hBFC0_0013, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80);
    load_zero_wait("lbu", 2'd0, 1'b0, 32'hBFC0_0013, 32'h8011_2233, 4'b1000, 32'h0000_0080);
    check("lbu_hold", resp_rdata, 32'h0000_0080);

    // Half store with three wait cycles
    drive_req(1'b1, 2'd1, 1'b0, 32'hBFC0_0006, 32'h0000_1234);
    waitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("sh_write", {31'b0, write}, 32'd1);
      check("sh_be", {28'b0, byteenable}, 32'hC);
      check("sh_wdata", writedata, 32'h1234_0000);
      check("sh_rv_early", {31'b0, resp_valid}, 32'd0);
      if (c == 4) waitrequest = 1'b0;
    end
    @(negedge clk);
    check("sh_rv", {31'b0, resp_valid}, 32'd1);
    check("sh_write_off", {31'b0, write}, 32'd0);
    check("sh_addr", address, 32'hBFC0_0004);
    @(negedge clk);

    // Misaligned word load
    mem_word = 32'hCAFE_F00D;
    drive_req(1'b0, 2'd2, 1'b0, 32'hBFC0_0002, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef MIPS_CPU_MISALIGN_TRAP_EN
    check("mis_read", {31'b0, read}, 32'd0);
    check("mis_rv", {31'b0, resp_valid}, 32'd1);
    check("mis_err", {31'b0, resp_err}, 32'd1);
    check("mis_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    check("mis_rv_pulse", {31'b0, resp_valid}, 32'd0);
    check("mis_err_off", {31'b0, resp_err}, 32'd0);
`else
    check("mis_read", {31'b0, read}, 32'd1);
    check("mis_addr", address, 32'hBFC0_0000);
    check("mis_be", {28'b0, byteenable}, 32'hF);
    @(negedge clk);
    @(negedge clk);
    check("mis_rv", {31'b0, resp_valid}, 32'd1);
    check("mis_err", {31'b0, resp_err}, 32'd0);
    check("mis_rdata", resp_rdata, 32'hCAFE_F00D);
    @(negedge clk);
`endif

    // Reset during the REQ cycle of a load
    @(negedge clk);
    resp_count = 0;
    mem_word = 32'h1111_1111;
    drive_req(1'b0, 2'd2, 1'b0, 32'hBFC0_0010, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rab_read", {31'b0, read}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rab_read_off", {31'b0, read}, 32'd0);
    check("rab_ready", {31'b0, req_ready}, 32'd1);
    check("rab_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    check("rab_no_resp", resp_count, 32'd0);
    load_zero_wait("rab_lh", 2'd1, 1'b1, 32'hBFC0_0012, 32'h8001_7777, 4'b1100, 32'hFFFF_8001);

    // req_valid held high: store then load
    resp_count = 0;
    drive_req(1'b1, 2'd0, 1'b0, 32'hBFC0_0021, 32'h0000_00AB);
    @(negedge clk);
    check("b2b_write", {31'b0, write}, 32'd1);
    check("b2b_sb_be", {28'b0, byteenable}, 32'h2);
    check("b2b_sb_wdata", writedata, 32'h0000_AB00);
    mem_word = 32'h00CD_0000;
    drive_req(1'b0, 2'd0, 1'b0, 32'hBFC0_0022, 32'h0);
    @(negedge clk);
    check("b2b_rv1", {31'b0, resp_valid}, 32'd1);
    check("b2b_read_c2", {31'b0, read}, 32'd0);
    @(negedge clk);
    check("b2b_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_read", {31'b0, read}, 32'd1);
    check("b2b_write_off", {31'b0, write}, 32'd0);
    check("b2b_lb_be", {28'b0, byteenable}, 32'h4);
    @(negedge clk);
    @(negedge clk);
    check("b2b_rv2", {31'b0, resp_valid}, 32'd1);
    check("b2b_rdata", resp_rdata, 32'h0000_00CD);
    repeat (3) @(negedge clk);
    check("b2b_resp_count", resp_count, 32'd2);
    check("strobe_clash", strobe_clash, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
